// File: rtl/rtc_date.sv
// rtc_date: calendar date register (day, month, weekday, year) in BCD.
//
// Ports
//   clk_i         : block clock, all state changes on its rising edge
//   rstn_i        : synchronous active-low reset (date -> Sat 2000-01-01)
//   new_day_i     : single-cycle day-advance pulse from the time-of-day block
//   date_update_i : single-cycle software load strobe for date_i
//   date_i[31:0]  : load value, same format as date_o
//   date_o[31:0]  : current date
//                   [5:0] day BCD, [12:8] month BCD, [15:13] weekday 0-6
//                   (0 = Sunday), [29:16] year BCD 0000-3999
//   new_month_o   : one-cycle pulse when the month rolls over
//   new_year_o    : one-cycle pulse when the year rolls over
//   load_err_o    : one-cycle pulse when a load is rejected
module rtc_date (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        new_day_i,
  input  logic        date_update_i,
  input  logic [31:0] date_i,
  output logic [31:0] date_o,
  output logic        new_month_o,
  output logic        new_year_o,
  output logic        load_err_o
);

  // Divisibility by 4 of a two-digit BCD number 10*t+u, i.e. of (2t+u):
  // with t even u must be 0/4/8, with t odd u must be 2/6.
  function automatic logic div4(input logic [3:0] t, input logic [3:0] u);
    logic r;
    if (t[0] == 1'b0) begin
      r = (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
    end else begin
      r = (u == 4'd2) || (u == 4'd6);
    end
    return r;
  endfunction

  // Gregorian leap rule on BCD digits: a century year (last two digits 00)
  // is leap only if its century number is divisible by 4.
  function automatic logic is_leap(input logic [13:0] y);
    logic r;
    if (y[7:0] == 8'h00) begin
      r = div4({2'b00, y[13:12]}, y[11:8]);
    end else begin
      r = div4(y[7:4], y[3:0]);
    end
    return r;
  endfunction

  // Number of days in a month, returned as a BCD day value.
  function automatic logic [5:0] month_len(input logic [4:0] mon, input logic leap);
    logic [5:0] r;
    case (mon)
      5'h04, 5'h06, 5'h09, 5'h11: r = 6'h30;
      5'h02:                      r = leap ? 6'h29 : 6'h28;
      default:                    r = 6'h31;
    endcase
    return r;
  endfunction

  // BCD year increment with 3999 -> 0000 wrap.
  function automatic logic [13:0] year_inc(input logic [13:0] y);
    logic [13:0] r;
    r = y;
    if (y[3:0] != 4'd9) begin
      r[3:0] = y[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (y[7:4] != 4'd9) begin
        r[7:4] = y[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (y[11:8] != 4'd9) begin
          r[11:8] = y[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[13:12] = (y[13:12] == 2'd3) ? 2'd0 : y[13:12] + 2'd1;
        end
      end
    end
    return r;
  endfunction

  logic [5:0]  day_q,  day_d;
  logic [4:0]  mon_q,  mon_d;
  logic [2:0]  wday_q, wday_d;
  logic [13:0] year_q, year_d;
  logic        new_month_q, new_month_d;
  logic        new_year_q,  new_year_d;
  logic        load_err_q,  load_err_d;

  logic        load_ok_s;
  logic [5:0]  cur_len_s;
  logic [5:0]  ld_len_s;
  logic        unused_s;

  // Reserved input bits carry no meaning.
  assign unused_s = ^{date_i[31:30], date_i[7:6]};

  assign cur_len_s = month_len(mon_q, is_leap(year_q));
  assign ld_len_s  = month_len(date_i[12:8], is_leap(date_i[29:16]));

  // Load validity: BCD digits, month range, weekday range, day within month.
  // Day tens (2 bits), month tens (1 bit) and year thousands (2 bits) cannot
  // exceed 9 by construction, so only the 4-bit digits need a range check.
  always_comb begin
    load_ok_s = (date_i[3:0]   <= 4'd9) && (date_i[11:8]  <= 4'd9) &&
                (date_i[19:16] <= 4'd9) && (date_i[23:20] <= 4'd9) &&
                (date_i[27:24] <= 4'd9) &&
                (date_i[12:8]  >= 5'h01) && (date_i[12:8] <= 5'h12) &&
                (date_i[15:13] <= 3'd6) &&
                (date_i[5:0]   != 6'h00) && (date_i[5:0] <= ld_len_s);
  end

  // Next-state: accepted load wins; otherwise apply the day advance and
  // flag a rejected load alongside any rollover pulses.
  always_comb begin
    day_d       = day_q;
    mon_d       = mon_q;
    wday_d      = wday_q;
    year_d      = year_q;
    new_month_d = 1'b0;
    new_year_d  = 1'b0;
    load_err_d  = 1'b0;
    if (date_update_i && load_ok_s) begin
      day_d  = date_i[5:0];
      mon_d  = date_i[12:8];
      wday_d = date_i[15:13];
      year_d = date_i[29:16];
    end else begin
      load_err_d = date_update_i;
      if (new_day_i) begin
        wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
        if (day_q != cur_len_s) begin
          if (day_q[3:0] == 4'd9) begin
            day_d = {day_q[5:4] + 2'd1, 4'd0};
          end else begin
            day_d = {day_q[5:4], day_q[3:0] + 4'd1};
          end
        end else begin
          day_d       = 6'h01;
          new_month_d = 1'b1;
          if (mon_q == 5'h12) begin
            mon_d      = 5'h01;
            year_d     = year_inc(year_q);
            new_year_d = 1'b1;
          end else if (mon_q[3:0] == 4'd9) begin
            mon_d = 5'h10;
          end else begin
            mon_d = {mon_q[4], mon_q[3:0] + 4'd1};
          end
        end
      end else begin
        day_d = day_q;
      end
    end
  end

  // State registers with synchronous active-low reset to Sat 2000-01-01.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      day_q       <= 6'h01;
      mon_q       <= 5'h01;
      wday_q      <= 3'd6;
      year_q      <= 14'h2000;
      new_month_q <= 1'b0;
      new_year_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      day_q       <= day_d;
      mon_q       <= mon_d;
      wday_q      <= wday_d;
      year_q      <= year_d;
      new_month_q <= new_month_d;
      new_year_q  <= new_year_d;
      load_err_q  <= load_err_d;
    end
  end

  assign date_o      = {2'b00, year_q, wday_q, mon_q, 2'b00, day_q};
  assign new_month_o = new_month_q;
  assign new_year_o  = new_year_q;
  assign load_err_o  = load_err_q;

endmodule

// File: tb/tb_rtc_date.sv
// Testbench for rtc_date: directed scenarios plus randomized traffic checked
// against an integer calendar model.
module tb_rtc_date;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        new_day_i = 1'b0;
  logic        date_update_i = 1'b0;
  logic [31:0] date_i = 32'h0;
  logic [31:0] date_o;
  logic        new_month_o, new_year_o, load_err_o;

  int vectors = 0;
  int miscompares = 0;

  // model state (plain integers)
  int my = 2000, mm = 1, md = 1, mwd = 6;
  logic em = 1'b0, ey = 1'b0, ee = 1'b0;

  rtc_date dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .new_day_i(new_day_i),
    .date_update_i(date_update_i), .date_i(date_i), .date_o(date_o),
    .new_month_o(new_month_o), .new_year_o(new_year_o), .load_err_o(load_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int dim(int y, int m);
    bit leap;
    leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    case (m)
      4, 6, 9, 11: return 30;
      2:           return leap ? 29 : 28;
      default:     return 31;
    endcase
  endfunction

  function automatic logic [31:0] enc(int y, int m, int d, int wd);
    return {2'b00, 2'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10),
            3'(wd), 1'(m / 10), 4'(m % 10), 2'b00, 2'(d / 10), 4'(d % 10)};
  endfunction

  // One clock cycle: drive inputs, advance the model at the edge, sample #1 later.
  task automatic step(input bit rst, input bit upd, input logic [31:0] w, input bit nd);
    int y, m, d, wd;
    bit ok;
    rstn_i = ~rst; date_update_i = upd; date_i = w; new_day_i = nd;
    @(posedge clk_i);
    em = 1'b0; ey = 1'b0; ee = 1'b0;
    ok = (w[3:0] <= 9) && (w[11:8] <= 9) && (w[19:16] <= 9) &&
         (w[23:20] <= 9) && (w[27:24] <= 9);
    y  = 1000 * int'(w[29:28]) + 100 * int'(w[27:24]) + 10 * int'(w[23:20]) + int'(w[19:16]);
    m  = 10 * int'(w[12]) + int'(w[11:8]);
    d  = 10 * int'(w[5:4]) + int'(w[3:0]);
    wd = int'(w[15:13]);
    ok = ok && m >= 1 && m <= 12 && wd <= 6 && d >= 1 && d <= dim(y, m);
    if (rst) begin
      my = 2000; mm = 1; md = 1; mwd = 6;
    end else if (upd && ok) begin
      my = y; mm = m; md = d; mwd = wd;
    end else begin
      ee = upd;
      if (nd) begin
        mwd = (mwd + 1) % 7;
        if (md < dim(my, mm)) md++;
        else begin
          md = 1; em = 1'b1;
          if (mm < 12) mm++;
          else begin mm = 1; ey = 1'b1; my = (my + 1) % 4000; end
        end
      end
    end
    #1;
    rstn_i = 1'b1; date_update_i = 1'b0; new_day_i = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, enc(2024, 5, 5, 1), 1);
      vectors++;
      if ({date_o, new_month_o, new_year_o, load_err_o} !== {32'h2000_C101, 3'b000}) begin
        miscompares++;
        $display("FAIL reset_hold: got %h %b%b%b expected 2000c101 000", date_o, new_month_o, new_year_o, load_err_o);
      end
    end
    step(0, 0, 32'h0, 0);
    vectors++;
    if ({date_o, new_month_o, new_year_o, load_err_o} !== {32'h2000_C101, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_release: got %h %b%b%b expected 2000c101 000", date_o, new_month_o, new_year_o, load_err_o);
    end
  endtask

  task automatic test_leap_feb();
    logic [34:0] exp_v [3];
    exp_v[0] = {enc(2024, 2, 28, 3), 3'b000};
    exp_v[1] = {enc(2024, 2, 29, 4), 3'b000};
    exp_v[2] = {enc(2024, 3, 1, 5), 3'b100};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(0, 1, enc(2024, 2, 28, 3), 0);
      else        step(0, 0, 32'h0, 1);
      vectors++;
      if ({date_o, new_month_o, new_year_o, load_err_o} !== exp_v[i]) begin
        miscompares++;
        $display("FAIL leap_feb[%0d]: got %h %b%b%b expected %h %b", i, date_o, new_month_o, new_year_o, load_err_o, exp_v[i][34:3], exp_v[i][2:0]);
      end
    end
  endtask

  task automatic test_century();
    step(0, 1, enc(1900, 2, 28, 1), 0);
    step(0, 0, 32'h0, 1);
    vectors++;
    if ({date_o, new_month_o, new_year_o, load_err_o} !== {enc(1900, 3, 1, 2), 3'b100}) begin
      miscompares++;
      $display("FAIL century_1900: got %h %b%b%b expected %h 100", date_o, new_month_o, new_year_o, load_err_o, enc(1900, 3, 1, 2));
    end
    step(0, 1, enc(2000, 2, 28, 1), 0);
    step(0, 0, 32'h0, 1);
    vectors++;
    if ({date_o, new_month_o, new_year_o, load_err_o} !== {enc(2000, 2, 29, 2), 3'b000}) begin
      miscompares++;
      $display("FAIL century_2000: got %h %b%b%b expected %h 000", date_o, new_month_o, new_year_o, load_err_o, enc(2000, 2, 29, 2));
    end
  endtask

  task automatic test_year_wrap();
    step(0, 1, enc(3999, 12, 31, 6), 0);
    step(0, 0, 32'h0, 1);
    vectors++;
    if ({date_o, new_month_o, new_year_o, load_err_o} !== {enc(0, 1, 1, 0), 3'b110}) begin
      miscompares++;
      $display("FAIL year_wrap: got %h %b%b%b expected %h 110", date_o, new_month_o, new_year_o, load_err_o, enc(0, 1, 1, 0));
    end
    step(0, 0, 32'h0, 0);
    vectors++;
    if ({new_month_o, new_year_o, load_err_o} !== 3'b000) begin
      miscompares++;
      $display("FAIL pulse_width: got %b%b%b expected 000", new_month_o, new_year_o, load_err_o);
    end
  endtask

  task automatic test_invalid_load();
    logic [31:0] w;
    step(0, 1, enc(2023, 2, 27, 1), 0);
    step(0, 1, enc(2023, 2, 29, 1), 1);
    vectors++;
    if ({date_o, new_month_o, new_year_o, load_err_o} !== {enc(2023, 2, 28, 2), 3'b001}) begin
      miscompares++;
      $display("FAIL invalid_plus_inc: got %h %b%b%b expected %h 001", date_o, new_month_o, new_year_o, load_err_o, enc(2023, 2, 28, 2));
    end
    w = enc(2023, 1, 15, 0);
    w[12:8] = 5'h13;
    step(0, 1, w, 0);
    vectors++;
    if ({date_o, new_month_o, new_year_o, load_err_o} !== {enc(2023, 2, 28, 2), 3'b001}) begin
      miscompares++;
      $display("FAIL bad_month: got %h %b%b%b expected %h 001", date_o, new_month_o, new_year_o, load_err_o, enc(2023, 2, 28, 2));
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1, enc(2025, 6, 15, 0), 1);
    vectors++;
    if ({date_o, new_month_o, new_year_o, load_err_o} !== {enc(2025, 6, 15, 0), 3'b000}) begin
      miscompares++;
      $display("FAIL load_priority: got %h %b%b%b expected %h 000", date_o, new_month_o, new_year_o, load_err_o, enc(2025, 6, 15, 0));
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 32'h0, 1);
      vectors++;
      if ({date_o, new_month_o, new_year_o, load_err_o} !== {enc(2025, 6, 15 + i, i), 3'b000}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h %b%b%b expected %h 000", i, date_o, new_month_o, new_year_o, load_err_o, enc(2025, 6, 15 + i, i));
      end
    end
    // reset mid-sequence, with strobes present, wins
    step(1, 1, enc(2025, 7, 1, 2), 1);
    vectors++;
    if ({date_o, new_month_o, new_year_o, load_err_o} !== {32'h2000_C101, 3'b000}) begin
      miscompares++;
      $display("FAIL mid_reset: got %h %b%b%b expected 2000c101 000", date_o, new_month_o, new_year_o, load_err_o);
    end
  endtask

  task automatic test_random();
    int r, y, m, d, wd;
    logic [31:0] w;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        step(1, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
      end else if (r < 20) begin
        y = $urandom_range(0, 3999); m = $urandom_range(1, 12);
        if ($urandom_range(0, 3) == 0) y = 100 * $urandom_range(0, 39);
        d = dim(y, m) - $urandom_range(0, 2); wd = $urandom_range(0, 6);
        w = enc(y, m, d, wd);
        if ($urandom_range(0, 4) == 0) w[5:0] = (m == 2) ? 6'h29 : 6'h31;
        step(0, 1, w, $urandom_range(0, 1));
      end else if (r < 28) begin
        step(0, 1, $urandom, $urandom_range(0, 1));
      end else begin
        step(0, 0, $urandom, r < 90);
      end
      vectors++;
      if ({date_o, new_month_o, new_year_o, load_err_o} !== {enc(my, mm, md, mwd), em, ey, ee}) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h %b%b%b expected %h %b%b%b", i, date_o, new_month_o, new_year_o, load_err_o, enc(my, mm, md, mwd), em, ey, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_leap_feb();
    test_century();
    test_year_wrap();
    test_invalid_load();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
